// File: rtl/adder_accum_array_if.sv
// adder_accum_array_if: beat-in / result-out handshake bundle for adder_accum_array
//   master: drives a_in, b_in, acc_mode, last_in, in_valid, out_ready
//   slave : drives in_ready, result_out, ovf_out, beat_cnt, out_valid, done
interface adder_accum_array_if #(
  parameter int N     = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic [LANES*N-1:0]     a_in, b_in;
  logic                   acc_mode, last_in, in_valid, in_ready;
  logic [LANES*ACC_W-1:0] result_out;
  logic [LANES-1:0]       ovf_out;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   out_valid, out_ready, done;
  modport master (
    output a_in, b_in, acc_mode, last_in, in_valid, out_ready,
    input  in_ready, result_out, ovf_out, beat_cnt, out_valid, done
  );
  modport slave (
    input  a_in, b_in, acc_mode, last_in, in_valid, out_ready,
    output in_ready, result_out, ovf_out, beat_cnt, out_valid, done
  );
endinterface

// File: rtl/adder_accum_array.sv
// adder_accum_array: LANES-wide a+b adder that returns one sum or accumulates a burst
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of adder_accum_array_if (input beats, registered per-lane results)
module adder_accum_array #(
  parameter int N      = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 16,
  parameter int SIGNED = 0,
  parameter int SAT    = 0,
  parameter int CNT_W  = 8
) (
  input logic                 clk,
  input logic                 reset,
  adder_accum_array_if.slave  bus
);
  localparam int M = ACC_W - 1;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t                 state_q;
  logic [LANES*ACC_W-1:0] res_q, first_d, acc_d;
  logic [LANES-1:0]       ovf_q, ov_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   done_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [N-1:0]     a, b;
    logic [ACC_W-1:0] s, r;
    logic [ACC_W:0]   t;
    logic             ov;
    assign a = bus.a_in[i*N +: N];
    assign b = bus.b_in[i*N +: N];
    // extending operands before adding equals extending the N+1-bit sum, since ACC_W >= N+1
    assign s = {{(ACC_W-N){SIGNED != 0 && a[N-1]}}, a} + {{(ACC_W-N){SIGNED != 0 && b[N-1]}}, b};
    assign r = res_q[i*ACC_W +: ACC_W];
    assign t = {1'b0, r} + {1'b0, s};
    assign ov = SIGNED != 0 ? (r[M] == s[M] && t[M] != r[M]) : t[ACC_W];
    assign ov_d[i] = ov;
    assign first_d[i*ACC_W +: ACC_W] = s;
    // signed overflow direction follows the accumulator sign, which equals the addend sign
    assign acc_d[i*ACC_W +: ACC_W] = (SAT != 0 && ov)
      ? (SIGNED == 0 ? {ACC_W{1'b1}} : r[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}})
      : t[M:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          res_q   <= first_d;
          ovf_q   <= '0;
          cnt_q   <= CNT_W'(1);
          state_q <= (!bus.acc_mode || bus.last_in) ? OUT : ACC;
        end
        ACC: if (bus.in_valid) begin
          res_q <= acc_d;
          ovf_q <= ovf_q | ov_d;
          cnt_q <= &cnt_q ? cnt_q : cnt_q + 1'b1;
          if (bus.last_in) state_q <= OUT;
        end
        OUT: if (bus.out_ready) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.in_ready   = state_q != OUT;
  assign bus.out_valid  = state_q == OUT;
  assign bus.result_out = res_q;
  assign bus.ovf_out    = ovf_q;
  assign bus.beat_cnt   = cnt_q;
  assign bus.done       = done_q;
endmodule
